boost_filter_seq: RTL
=====================

Name: boost_filter_seq

Overview:
Frame-level sequencer for the 3-channel boost filter datapath.
- Pops 3x3 window samples from the upstream window FIFO and pulses the filter's data_in once per pixel.
- Tracks issued and retired pixel positions in raster order and throttles issue against downstream almost-full.
- Emits frame/line framing (sof, eol, frame_done) aligned to the filter's combined wr_en.
- Sits between the line-buffer/window FIFO and the result writer.

Parameters:
IMG_W, 640, pixels per line (>=2)
IMG_H, 480, lines per frame (>=2)
FILT_LAT, 3, fixed cycles from data_in to combined filter wr_en (>=1)
MAX_INFL, 8, max pixels in flight inside filter (>=FILT_LAT)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
frame_start  in  1  one-cycle pulse; arms a new frame when idle
win_empty  in  1  upstream window FIFO empty
win_rd  out  1  pop window FIFO; identical to data_in
data_in  out  1  pixel strobe to filter, all three channels
filt_wr_en  in  1  combined filter wr_en (AND of R/G/B)
out_afull  in  1  downstream almost-full; blocks new issue
out_sof  out  1  high with first filt_wr_en of frame
out_eol  out  1  high with filt_wr_en of last pixel in a line
frame_done  out  1  one-cycle pulse, cycle after last retire
busy  out  1  state != IDLE
lat_err  out  1  sticky: filt_wr_en disagreed with expected retire
issue_col  out  log2(IMG_W)  column of next pixel to issue
issue_row  out  log2(IMG_H)  row of next pixel to issue

Behaviour:
- Clock/reset: one clock, clk; reset synchronous active-low, rst_n, sampled on posedge clk. All outputs and state 0 in reset: state IDLE, counters 0, win_rd/data_in 0, out_sof/out_eol/frame_done 0, busy 0, lat_err 0.
- FSM: IDLE -> RUN on frame_start. RUN -> DRAIN when the last pixel (IMG_H-1, IMG_W-1) issues. DRAIN -> DONE when in-flight count reaches 0 and the retire counter equals IMG_W*IMG_H. DONE -> IDLE after one cycle; frame_done is high during DONE.
- frame_start is ignored outside IDLE. frame_start in the same cycle as DONE is dropped.
- Issue condition, RUN only: !win_empty && !out_afull && infl < MAX_INFL. When true, data_in = win_rd = 1 combinationally that cycle.
- Issue counters advance on issue. Column wraps at IMG_W-1 to 0 and increments row; row wraps to 0 after the frame.
- infl counter: +1 on issue, -1 on filt_wr_en, unchanged on both together. Width covers MAX_INFL.
- Expected-retire shift register, FILT_LAT deep, shifted every cycle, input = issue.
  - Any cycle where filt_wr_en != tap output sets lat_err, held until reset.
  - On filt_wr_en with infl==0: infl saturates at 0 and lat_err is set.
- Retire counters (ret_col, ret_row) advance on filt_wr_en.
  - out_sof = filt_wr_en && ret_col==0 && ret_row==0.
  - out_eol = filt_wr_en && ret_col==IMG_W-1.
- out_afull asserted mid-line: issue stalls; in-flight pixels still retire; framing unaffected.
- rst_n low mid-frame: FSM, counters and shift register clear next edge. Upstream FIFO flush is the owner's responsibility.
- Issue-to-out_sof latency: exactly FILT_LAT cycles.

Optional Feature:
Macro BOOST_BORDER_BYPASS_EN.
- Defined: adds output border_byp (1 bit). A per-pixel flag marks row 0, row IMG_H-1, col 0 or col IMG_W-1 at issue. The flag is delayed through a FILT_LAT-deep shift register and presented with filt_wr_en, so the result mux passes the centre pixel unfiltered. Reset 0.
- Undefined: port and shift register absent; border pixels are filtered like interior ones.

Decomposition:
- Package boost_pkg: FSM state encoding (IDLE/RUN/DRAIN/DONE), default IMG_W/IMG_H, counter width constants derived via $clog2.
- One sub-module: boost_lat_pipe, a parameterised 1-bit FILT_LAT-deep shift register. Instantiated for expected-retire and, when the feature is enabled, for the border flag.

Test Plan:
- IMG_W=4, IMG_H=2, FILT_LAT=3, win_empty=0, ideal filter model: frame_start -> 8 data_in pulses on consecutive cycles; out_sof 3 cycles after first issue; out_eol on retires 4 and 8; frame_done exactly 1 cycle after retire 8; lat_err=0.
- out_afull high for 5 cycles after issue 2 -> no data_in during stall; pixels 1-2 still retire; total retire count 8; framing correct.
- MAX_INFL=3, filter model delays wr_en by 10 cycles -> infl never exceeds 3; issue resumes on each retire.
- Filter model drops one wr_en -> lat_err set and stays set; FSM stays in DRAIN, no frame_done.
- rst_n low at issue 5 -> next cycle busy=0, issue_col=issue_row=0; new frame_start completes normally.
- BOOST_BORDER_BYPASS_EN defined, IMG_W=3, IMG_H=3 -> border_byp=1 on all retires except retire 5 (centre).

Source files
------------

// File: rtl/boost_pkg.sv
`default_nettype none
// ============================================================================
// Package : boost_pkg
// Brief   : Shared state encoding and default geometry for the boost filter
//           sequencer.
// Rev     : 1.0 - initial release
// ============================================================================
package boost_pkg;

    localparam int c_img_w_def = 640;
    localparam int c_img_h_def = 480;
    localparam int c_col_w_def = $clog2(c_img_w_def);
    localparam int c_row_w_def = $clog2(c_img_h_def);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/boost_lat_pipe.sv
`default_nettype none
// ============================================================================
// Module : boost_lat_pipe
// Brief  : 1-bit DEPTH-deep shift register tracking flags through the fixed
//          filter latency.
// Rev    : 1.0 - initial release
// ============================================================================
module boost_lat_pipe #(
    parameter int DEPTH = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] r_sr;

    generate
        if (DEPTH == 1) begin : g_single
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_sr <= '0;
                end else begin
                    r_sr <= din;
                end
            end
        end else begin : g_multi
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_sr <= '0;
                end else begin
                    r_sr <= {r_sr[DEPTH-2:0], din};
                end
            end
        end
    endgenerate

    assign dout = r_sr[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/boost_filter_seq.sv
`default_nettype none
// ============================================================================
// Module : boost_filter_seq
// Brief  : Frame sequencer for the 3-channel boost filter: issues window pops,
//          tracks in-flight pixels, emits framing aligned to filter wr_en.
//          Optional border bypass flag enabled by BOOST_BORDER_BYPASS_EN.
// Rev    : 1.0 - initial release
// ============================================================================
module boost_filter_seq
    import boost_pkg::*;
#(
    parameter int IMG_W    = c_img_w_def,
    parameter int IMG_H    = c_img_h_def,
    parameter int FILT_LAT = 3,
    parameter int MAX_INFL = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     frame_start,
    input  logic                     win_empty,
    output logic                     win_rd,
    output logic                     data_in,
    input  logic                     filt_wr_en,
    input  logic                     out_afull,
    output logic                     out_sof,
    output logic                     out_eol,
    output logic                     frame_done,
    output logic                     busy,
    output logic                     lat_err,
    output logic [$clog2(IMG_W)-1:0] issue_col,
    output logic [$clog2(IMG_H)-1:0] issue_row
`ifdef BOOST_BORDER_BYPASS_EN
    ,
    output logic                     border_byp
`endif
);

    localparam int c_col_w  = $clog2(IMG_W);
    localparam int c_row_w  = $clog2(IMG_H);
    localparam int c_total  = IMG_W * IMG_H;
    localparam int c_ret_w  = $clog2(c_total + 1);
    localparam int c_infl_w = $clog2(MAX_INFL + 1);

    localparam logic [c_col_w-1:0]  c_col_last  = c_col_w'(IMG_W - 1);
    localparam logic [c_row_w-1:0]  c_row_last  = c_row_w'(IMG_H - 1);
    localparam logic [c_ret_w-1:0]  c_ret_total = c_ret_w'(c_total);
    localparam logic [c_infl_w-1:0] c_infl_max  = c_infl_w'(MAX_INFL);

    state_t              r_state;
    logic [c_col_w-1:0]  r_col;
    logic [c_row_w-1:0]  r_row;
    logic [c_col_w-1:0]  r_ret_col;
    logic [c_row_w-1:0]  r_ret_row;
    logic [c_ret_w-1:0]  r_ret_cnt;
    logic [c_infl_w-1:0] r_infl;
    logic                r_busy;
    logic                r_frame_done;
    logic                r_lat_err;

    logic                w_issue;
    logic                w_last_issue;
    logic                w_exp_ret;
    logic [c_infl_w-1:0] w_infl_nxt;
    logic [c_ret_w-1:0]  w_ret_cnt_nxt;

    assign w_issue      = (r_state == ST_RUN) && !win_empty && !out_afull && (r_infl < c_infl_max);
    assign w_last_issue = w_issue && (r_col == c_col_last) && (r_row == c_row_last);

    // A retire with nothing in flight is an error; the count saturates at 0.
    always_comb begin
        w_infl_nxt = r_infl;
        if (w_issue && !filt_wr_en) begin
            w_infl_nxt = r_infl + 1'b1;
        end else if (!w_issue && filt_wr_en && (r_infl != '0)) begin
            w_infl_nxt = r_infl - 1'b1;
        end
    end

    always_comb begin
        w_ret_cnt_nxt = r_ret_cnt;
        if (filt_wr_en) begin
            w_ret_cnt_nxt = r_ret_cnt + 1'b1;
        end
    end

    boost_lat_pipe #(
        .DEPTH (FILT_LAT)
    ) u_ret_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (w_issue),
        .dout  (w_exp_ret)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_col        <= '0;
            r_row        <= '0;
            r_ret_col    <= '0;
            r_ret_row    <= '0;
            r_ret_cnt    <= '0;
            r_infl       <= '0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_lat_err    <= 1'b0;
        end else begin
            r_infl    <= w_infl_nxt;
            r_ret_cnt <= w_ret_cnt_nxt;

            if (w_issue) begin
                if (r_col == c_col_last) begin
                    r_col <= '0;
                    r_row <= (r_row == c_row_last) ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end

            if (filt_wr_en) begin
                if (r_ret_col == c_col_last) begin
                    r_ret_col <= '0;
                    r_ret_row <= (r_ret_row == c_ret_row_last_f()) ? '0 : r_ret_row + 1'b1;
                end else begin
                    r_ret_col <= r_ret_col + 1'b1;
                end
            end

            if ((filt_wr_en != w_exp_ret) || (filt_wr_en && (r_infl == '0))) begin
                r_lat_err <= 1'b1;
            end

            // Completion looks at next-cycle counts so frame_done lands one
            // cycle after the final retire.
            case (r_state)
                ST_IDLE: begin
                    if (frame_start) begin
                        r_state   <= ST_RUN;
                        r_busy    <= 1'b1;
                        r_ret_cnt <= '0;
                    end
                end
                ST_RUN: begin
                    if (w_last_issue) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if ((w_infl_nxt == '0) && (w_ret_cnt_nxt == c_ret_total)) begin
                        r_state      <= ST_DONE;
                        r_frame_done <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state      <= ST_IDLE;
                    r_busy       <= 1'b0;
                    r_frame_done <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    function automatic logic [c_row_w-1:0] c_ret_row_last_f();
        return c_row_last;
    endfunction

    assign win_rd     = w_issue;
    assign data_in    = w_issue;
    assign out_sof    = filt_wr_en && (r_ret_col == '0) && (r_ret_row == '0);
    assign out_eol    = filt_wr_en && (r_ret_col == c_col_last);
    assign frame_done = r_frame_done;
    assign busy       = r_busy;
    assign lat_err    = r_lat_err;
    assign issue_col  = r_col;
    assign issue_row  = r_row;

`ifdef BOOST_BORDER_BYPASS_EN
    logic w_border;
    logic w_border_tap;

    assign w_border = w_issue && ((r_row == '0) || (r_row == c_row_last) ||
                                  (r_col == '0) || (r_col == c_col_last));

    boost_lat_pipe #(
        .DEPTH (FILT_LAT)
    ) u_border_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (w_border),
        .dout  (w_border_tap)
    );

    assign border_byp = filt_wr_en && w_border_tap;
`endif

endmodule
`default_nettype wire
